// File: rtl/conv_encoder_param.sv
// Rate-1/NUM_OUT convolutional encoder, tail-biting or zero-terminated.
// Serial encode, MSB first, packed per-stream output words over valid/ready.
module conv_encoder_param #(
  parameter int unsigned K       = 7,
  parameter int unsigned NUM_OUT = 3,
  parameter logic [NUM_OUT*K-1:0] GEN = {7'o165, 7'o171, 7'o133},
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned LEN_W   = 13
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         blk_len,
  input  logic                     mode,
  input  logic [K-2:0]             tail_bits,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*OUT_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     len_err
);

  localparam int unsigned BC_W = $clog2(IN_W);
  localparam int unsigned FL_W = $clog2(OUT_W);
  localparam int unsigned FC_W = $clog2(K);

  localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(IN_W - 1);
  localparam logic [FL_W-1:0] FILL_LAST  = FL_W'(OUT_W - 1);
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(K - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ENC,
    FLUSH,
    DRAIN
  } state_e;

  state_e                          state_q;
  logic [K-2:0]                    s_q;
  logic [IN_W-1:0]                 word_q;
  logic [BC_W-1:0]                 bit_cnt_q;
  logic [LEN_W-1:0]                len_q;
  logic [LEN_W-1:0]                word_cnt_q;
  logic                            mode_q;
  logic [FC_W-1:0]                 flush_cnt_q;
  logic [FL_W-1:0]                 fill_q;
  logic [NUM_OUT-1:0][OUT_W-1:0]   acc_q;
  logic [NUM_OUT-1:0][OUT_W-1:0]   acc_d;
  logic [NUM_OUT-1:0][OUT_W-1:0]   out_q;
  logic                            out_valid_q;
  logic                            out_last_q;
  logic                            in_ready_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            len_err_q;

  logic                            u;
  logic [K-1:0]                    x_vec;
  logic [NUM_OUT-1:0]              d;
  logic [K-2:0]                    preload;
  logic                            step;
  logic                            word_end;
  logic                            blk_end;
  logic                            emit;
  logic                            stall;
  logic                            advance;
  logic                            out_hs;

  // s_q[K-2] holds s[1] (newest), s_q[0] holds s[K-1] (oldest),
  // so {u, s_q} lines up bit-for-bit with each generator.
  always_comb begin
    u     = (state_q == ENC) ? word_q[IN_W-1] : 1'b0;
    x_vec = {u, s_q};
    for (int j = 0; j < NUM_OUT; j++) begin
      d[j] = ^(GEN[j*K +: K] & x_vec);
    end
    for (int k = 0; k < K - 1; k++) begin
      preload[k] = mode ? 1'b0 : tail_bits[K-2-k];
    end
  end

  always_comb begin
    step     = (state_q == ENC) || (state_q == FLUSH);
    word_end = (state_q == ENC) && (bit_cnt_q == BIT_LAST);
    if (state_q == FLUSH) begin
      blk_end = (flush_cnt_q == FLUSH_LAST);
    end else begin
      blk_end = word_end && (word_cnt_q == len_q) && !mode_q;
    end
    emit    = step && ((fill_q == FILL_LAST) || blk_end);
    out_hs  = out_valid_q && out_ready;
    stall   = emit && out_valid_q && !out_ready;
    advance = step && !stall;
    acc_d   = acc_q;
    for (int j = 0; j < NUM_OUT; j++) begin
      acc_d[j][FILL_LAST - fill_q] = d[j];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      word_q      <= '0;
      bit_cnt_q   <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      mode_q      <= 1'b0;
      flush_cnt_q <= '0;
      fill_q      <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      len_err_q <= 1'b0;

      if (out_hs) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end

      // A completed word overrides the handshake clear: no bubble.
      if (advance) begin
        s_q <= {u, s_q[K-2:1]};
        if (emit) begin
          out_q       <= acc_d;
          out_valid_q <= 1'b1;
          out_last_q  <= blk_end;
          acc_q       <= '0;
          fill_q      <= '0;
        end else begin
          acc_q  <= acc_d;
          fill_q <= fill_q + 1'b1;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (blk_len == '0) begin
              len_err_q <= 1'b1;
            end else begin
              len_q      <= blk_len;
              mode_q     <= mode;
              s_q        <= preload;
              word_cnt_q <= '0;
              acc_q      <= '0;
              fill_q     <= '0;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            word_q     <= in_data;
            word_cnt_q <= word_cnt_q + 1'b1;
            bit_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ENC;
          end
        end
        ENC: begin
          if (advance) begin
            word_q    <= word_q << 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (word_end) begin
              bit_cnt_q <= '0;
              if (word_cnt_q != len_q) begin
                in_ready_q <= 1'b1;
                state_q    <= LOAD;
              end else if (mode_q) begin
                flush_cnt_q <= '0;
                state_q     <= FLUSH;
              end else begin
                state_q <= DRAIN;
              end
            end
          end
        end
        FLUSH: begin
          if (advance) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
            if (blk_end) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_conv_encoder_param.sv
// Bench for conv_encoder_param: scoreboard of expected coded words
// from a bit-serial reference encoder, plus directed corner cases.
module tb_conv_encoder_param;

  localparam int K  = 7;
  localparam int NO = 3;
  localparam int IW = 8;
  localparam int OW = 8;
  localparam int LW = 13;
  localparam logic [NO*K-1:0] GEN = {7'o165, 7'o171, 7'o133};

  typedef struct packed {
    logic [NO*OW-1:0] data;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [LW-1:0]    blk_len = '0;
  logic             mode = 1'b0;
  logic [K-2:0]     tail_bits = '0;
  logic [IW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NO*OW-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             len_err;

  int               checks = 0;
  int               errors = 0;
  bit               rnd_en = 1'b0;
  exp_t             sb[$];
  exp_t             e;
  logic [IW-1:0]    blk_data[$];
  bit               stall_pend = 1'b0;
  logic [NO*OW-1:0] held = '0;

  conv_encoder_param dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .blk_len   (blk_len),
    .mode      (mode),
    .tail_bits (tail_bits),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [NO*OW-1:0] dat, input logic lst);
    exp_t x;
    x.data = dat;
    x.last = lst;
    sb.push_back(x);
  endtask

  // Reference encoder: explicit s[1..K-1] shift register, bit by bit.
  task automatic push_model(input int len, input bit md,
                            input logic [K-2:0] tl);
    logic [K-1:1]           sv;
    logic [NO-1:0][OW-1:0]  acc;
    logic [IW-1:0]          wd;
    logic [K-1:0]           g;
    logic                   ub;
    logic                   db;
    int                     total;
    int                     fill;
    for (int i = 1; i < K; i++) sv[i] = md ? 1'b0 : tl[i-1];
    acc   = '0;
    fill  = 0;
    total = len * IW + (md ? K - 1 : 0);
    for (int b = 0; b < total; b++) begin
      ub = 1'b0;
      if (b < len * IW) begin
        wd = blk_data[b / IW];
        ub = wd[IW - 1 - (b % IW)];
      end
      for (int j = 0; j < NO; j++) begin
        g  = GEN[j*K +: K];
        db = ub & g[K-1];
        for (int i = 1; i < K; i++) db = db ^ (sv[i] & g[K-1-i]);
        acc[j][OW-1-fill] = db;
      end
      for (int i = K - 1; i > 1; i--) sv[i] = sv[i-1];
      sv[1] = ub;
      fill++;
      if (fill == OW || b == total - 1) begin
        push_exp(acc, b == total - 1);
        acc  = '0;
        fill = 0;
      end
    end
  endtask

  task automatic start_blk(input string tag, input int len, input bit md,
                           input logic [K-2:0] tl);
    @(posedge clk); #1;
    blk_len   = LW'(len);
    mode      = md;
    tail_bits = tl;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_in_ready_up"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy_up"}, 32'(busy), 32'd1);
  endtask

  task automatic feed(input string tag, input int first, input int cnt);
    bit got;
    for (int w = first; w < first + cnt; w++) begin
      @(posedge clk); #1;
      in_data  = blk_data[w];
      in_valid = 1'b1;
      got      = 1'b0;
      for (int n = 0; n < 3000 && !got; n++) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!got) chk({tag, "_in_timeout"}, 32'(got), 32'd1);
    end
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 4000 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"},
        32'({out_valid, out_last, in_ready, busy, done, len_err}), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: hold-while-stalled and scoreboard pop on handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held));
      end
      stall_pend = out_valid && !out_ready;
      held       = out_data;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("word", 32'(out_data), 32'(e.data));
          chk("last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0]  lb;
    logic [K-2:0]   tl;
    logic [K-2:0]   es;

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // T1: impulse, zero-terminated
    blk_data.delete();
    blk_data.push_back(8'h80);
    push_exp(24'hEAF2B6, 1'b0);
    push_exp(24'h000000, 1'b1);
    start_blk("t1", 1, 1'b1, '0);
    feed("t1", 0, 1);
    wait_done("t1");

    // T2: all ones, tail-biting
    blk_data.delete();
    blk_data.push_back(8'hFF);
    push_exp(24'hFFFFFF, 1'b1);
    start_blk("t2", 1, 1'b0, 6'h3F);
    feed("t2", 0, 1);
    wait_done("t2");

    // T3: 40 random words, tail-biting
    blk_data.delete();
    for (int i = 0; i < 40; i++) blk_data.push_back(IW'($urandom));
    lb = blk_data[39];
    tl = lb[K-2:0];
    for (int k = 0; k < K - 1; k++) es[k] = tl[K-2-k];
    push_model(40, 1'b0, tl);
    start_blk("t3", 40, 1'b0, tl);
    feed("t3", 0, 40);
    wait_done("t3");
    chk("t3_final_state", 32'(dut.s_q), 32'(es));

    // T4: same block under random backpressure
    push_model(40, 1'b0, tl);
    rnd_en = 1'b1;
    start_blk("t4", 40, 1'b0, tl);
    feed("t4", 0, 40);
    wait_done("t4");
    chk("t4_final_state", 32'(dut.s_q), 32'(es));
    rnd_en = 1'b0;

    // T4b: zero-terminated random block under backpressure
    push_model(5, 1'b1, '0);
    rnd_en = 1'b1;
    start_blk("t4b", 5, 1'b1, '0);
    feed("t4b", 0, 5);
    wait_done("t4b");
    rnd_en = 1'b0;

    // T5: zero-length start
    @(posedge clk); #1;
    blk_len = '0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t5_len_err", 32'(len_err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t5_len_err_pulse", 32'(len_err), 32'd0);
    chk("t5_in_ready_2", 32'(in_ready), 32'd0);

    // T6: reset mid-block, then a clean T1 block
    blk_data.delete();
    for (int i = 0; i < 4; i++) blk_data.push_back(IW'($urandom));
    push_model(4, 1'b0, 6'h15);
    start_blk("t6", 4, 1'b0, 6'h15);
    feed("t6", 0, 2);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("t6_rst");
    sb.delete();
    @(negedge clk);
    chk_idle_outputs("t6_rst2");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_partial", 32'({out_valid, busy}), 32'd0);
    blk_data.delete();
    blk_data.push_back(8'h80);
    push_exp(24'hEAF2B6, 1'b0);
    push_exp(24'h000000, 1'b1);
    start_blk("t6_t1", 1, 1'b1, '0);
    feed("t6_t1", 0, 1);
    wait_done("t6_t1");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
